// File: rtl/wb_pkg.sv
// Shared types and default widths for the Wishbone master bridge.
package wb_pkg;

    localparam int wb_addr_width     = 32;
    localparam int wb_data_width     = 32;
    localparam int wb_timeout_cycles = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [wb_data_width-1:0] data;
        logic                     err;
    } wb_resp_t;

endpackage

// File: rtl/wb_bus.sv
// Wishbone classic bus bundle; the bridge uses the Master modport.
interface WishboneBus #(
    parameter int addr_width   = 32,
    parameter int data_width   = 32,
    parameter int strobe_width = data_width / 8
);
    logic [addr_width-1:0]   adr;
    logic [data_width-1:0]   datwr;
    logic [data_width-1:0]   datrd;
    logic [strobe_width-1:0] sel;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic                    ack;

    modport Master (output adr, datwr, sel, we, cyc, stb, input datrd, ack);
    modport Slave  (input adr, datwr, sel, we, cyc, stb, output datrd, ack);
endinterface

// File: rtl/wb_watchdog.sv
// Abort counter for unacknowledged Wishbone cycles (only built with WB_TIMEOUT_EN).
module wb_watchdog #(
    parameter int timeout_cycles = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expired
);
    localparam int cnt_width = $clog2(timeout_cycles + 1);

    logic [cnt_width-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || start) begin
            count <= '0;
        end else if (active && !ack && count != cnt_width'(timeout_cycles)) begin
            count <= count + cnt_width'(1);
        end
    end

    // Fires in the last allowed stb cycle so stb is high for exactly timeout_cycles cycles.
    assign expired = active && (count == cnt_width'(timeout_cycles - 1));

endmodule

// File: rtl/wb_master_bridge.sv
// Valid/ready request/response to Wishbone classic master bridge, one outstanding transaction.
// Optional watchdog abort enabled by defining WB_TIMEOUT_EN.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int addr_width     = wb_addr_width,
    parameter int data_width     = wb_data_width,
    parameter int strobe_width   = data_width / 8,
    parameter int timeout_cycles = wb_timeout_cycles
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [addr_width-1:0]   req_addr,
    input  logic [data_width-1:0]   req_data,
    input  logic [strobe_width-1:0] req_strobe,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [data_width-1:0]   resp_data,
    output logic                    resp_err,
    output logic [1:0]              debug_state,
    WishboneBus.Master              wb
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload are held stable until that edge.

    wb_state_t               state, state_next;
    logic [addr_width-1:0]   adr_q;
    logic [data_width-1:0]   datwr_q;
    logic [strobe_width-1:0] sel_q;
    logic                    we_q;
    logic                    bus_q;
    logic                    resp_valid_q;
    wb_resp_t                resp_q;
    logic                    accept, done, abort, expired;

`ifdef WB_TIMEOUT_EN
    wb_watchdog #(.timeout_cycles(timeout_cycles)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .start   (accept),
        .active  (state == BUS),
        .ack     (wb.ack),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                // ack wins over a simultaneous abort.
                if (wb.ack) begin
                    done       = 1'b1;
                    state_next = RESP;
                end else if (expired) begin
                    abort      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            adr_q        <= '0;
            datwr_q      <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            bus_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                adr_q   <= req_addr;
                datwr_q <= req_data;
                sel_q   <= req_strobe;
                we_q    <= req_we;
                bus_q   <= 1'b1;
            end
            if (done || abort) begin
                bus_q        <= 1'b0;
                resp_valid_q <= 1'b1;
                resp_q.data  <= (done && !we_q) ? wb.datrd : '0;
                resp_q.err   <= abort;
            end
            if (state == RESP && resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign wb.adr      = adr_q;
    assign wb.datwr    = datwr_q;
    assign wb.sel      = sel_q;
    assign wb.we       = we_q;
    assign wb.cyc      = bus_q;
    assign wb.stb      = bus_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_q.data;
    assign resp_err    = resp_q.err;
    assign debug_state = state;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge; timeout scenarios run when WB_TIMEOUT_EN is defined.
module tb_wb_master_bridge;
    import wb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strobe;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [1:0]  debug_state;

    int checks = 0;
    int errors = 0;

    WishboneBus #(.addr_width(32), .data_width(32)) bus ();

    wb_master_bridge dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_strobe  (req_strobe),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .debug_state (debug_state),
        .wb          (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strobe);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_data   = data;
        req_strobe = strobe;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
        req_strobe = '0; resp_ready = 1'b0; bus.ack = 1'b0; bus.datrd = '0;
        step(); step();

        // Reset values
        chk("rst_cyc", 64'(bus.cyc), 64'd0);
        chk("rst_stb", 64'(bus.stb), 64'd0);
        chk("rst_we", 64'(bus.we), 64'd0);
        chk("rst_adr", 64'(bus.adr), 64'd0);
        chk("rst_datwr", 64'(bus.datwr), 64'd0);
        chk("rst_sel", 64'(bus.sel), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_state", 64'(debug_state), 64'(IDLE));
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        reset = 1'b0;
        step();

        // Read with zero-wait ack
        offer(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        chk("rd_req_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        chk("rd_cyc", 64'(bus.cyc), 64'd1);
        chk("rd_stb", 64'(bus.stb), 64'd1);
        chk("rd_adr", 64'(bus.adr), 64'h10);
        chk("rd_we", 64'(bus.we), 64'd0);
        chk("rd_busy", 64'(req_ready), 64'd0);
        chk("rd_no_resp_yet", 64'(resp_valid), 64'd0);
        bus.ack = 1'b1; bus.datrd = 32'hDEAD_BEEF;
        step();
        bus.ack = 1'b0;
        chk("rd_cyc_drop", 64'(bus.cyc), 64'd0);
        chk("rd_stb_drop", 64'(bus.stb), 64'd0);
        chk("rd_resp_valid", 64'(resp_valid), 64'd1);
        chk("rd_resp_data", 64'(resp_data), 64'hDEAD_BEEF);
        chk("rd_resp_err", 64'(resp_err), 64'd0);
        chk("rd_state", 64'(debug_state), 64'(RESP));
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("rd_done_valid", 64'(resp_valid), 64'd0);
        chk("rd_done_ready", 64'(req_ready), 64'd1);

        // Write with 3 wait states
        offer(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011);
        step();
        req_valid = 1'b0;
        bus.datrd = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr_stb_%0d", i), 64'(bus.stb), 64'd1);
            chk($sformatf("wr_cyc_%0d", i), 64'(bus.cyc), 64'd1);
            chk($sformatf("wr_datwr_%0d", i), 64'(bus.datwr), 64'h1234_5678);
            chk($sformatf("wr_sel_%0d", i), 64'(bus.sel), 64'h3);
            chk($sformatf("wr_adr_%0d", i), 64'(bus.adr), 64'h20);
            chk($sformatf("wr_we_%0d", i), 64'(bus.we), 64'd1);
            chk($sformatf("wr_no_resp_%0d", i), 64'(resp_valid), 64'd0);
            bus.ack = (i == 3);
            step();
        end
        bus.ack = 1'b0;
        chk("wr_stb_drop", 64'(bus.stb), 64'd0);
        chk("wr_resp_valid", 64'(resp_valid), 64'd1);
        chk("wr_resp_data", 64'(resp_data), 64'd0);
        chk("wr_resp_err", 64'(resp_err), 64'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("wr_done_valid", 64'(resp_valid), 64'd0);

        // resp_ready held low for 5 cycles with a new request waiting
        offer(1'b0, 32'h0000_0044, 32'h0, 4'hF);
        step();
        req_valid = 1'b0;
        bus.ack = 1'b1; bus.datrd = 32'hA5A5_0F0F;
        step();
        bus.ack = 1'b0; bus.datrd = 32'h0;
        offer(1'b0, 32'h0000_0080, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_valid_%0d", i), 64'(resp_valid), 64'd1);
            chk($sformatf("hold_data_%0d", i), 64'(resp_data), 64'hA5A5_0F0F);
            chk($sformatf("hold_req_ready_%0d", i), 64'(req_ready), 64'd0);
            chk($sformatf("hold_cyc_%0d", i), 64'(bus.cyc), 64'd0);
            step();
        end
        resp_ready = 1'b1;
        chk("hold_last_valid", 64'(resp_valid), 64'd1);
        step();
        resp_ready = 1'b0;
        chk("hold_released", 64'(resp_valid), 64'd0);
        chk("hold_req_ready", 64'(req_ready), 64'd1);
        chk("hold_not_accepted", 64'(bus.cyc), 64'd0);
        step();
        req_valid = 1'b0;
        chk("next_cyc", 64'(bus.cyc), 64'd1);
        chk("next_adr", 64'(bus.adr), 64'h80);
        bus.ack = 1'b1; bus.datrd = 32'h0BAD_F00D;
        step();
        bus.ack = 1'b0;
        chk("next_data", 64'(resp_data), 64'h0BAD_F00D);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Spurious ack in IDLE
        bus.ack = 1'b1; bus.datrd = 32'h0000_5555;
        step(); step();
        chk("sp_idle_state", 64'(debug_state), 64'(IDLE));
        chk("sp_idle_resp", 64'(resp_valid), 64'd0);
        chk("sp_idle_cyc", 64'(bus.cyc), 64'd0);
        bus.ack = 1'b0;

        // Spurious ack in RESP
        offer(1'b0, 32'h0000_0030, 32'h0, 4'hF);
        step();
        req_valid = 1'b0;
        bus.ack = 1'b1; bus.datrd = 32'h7777_0001;
        step();
        chk("sp_resp_valid", 64'(resp_valid), 64'd1);
        chk("sp_resp_data", 64'(resp_data), 64'h7777_0001);
        bus.datrd = 32'h0000_9999;
        step();
        chk("sp_resp_state", 64'(debug_state), 64'(RESP));
        chk("sp_resp_data_kept", 64'(resp_data), 64'h7777_0001);
        resp_ready = 1'b1;
        step();
        bus.ack = 1'b0; resp_ready = 1'b0;
        chk("sp_resp_cleared", 64'(resp_valid), 64'd0);
        step();
        chk("sp_no_extra_resp", 64'(resp_valid), 64'd0);
        chk("sp_back_idle", 64'(debug_state), 64'(IDLE));

        // Reset in the middle of a bus cycle
        offer(1'b1, 32'h0000_0040, 32'h0000_CAFE, 4'hF);
        step();
        req_valid = 1'b0;
        chk("mr_cyc_before", 64'(bus.cyc), 64'd1);
        step();
        reset = 1'b1;
        step();
        chk("mr_cyc", 64'(bus.cyc), 64'd0);
        chk("mr_stb", 64'(bus.stb), 64'd0);
        chk("mr_req_ready", 64'(req_ready), 64'd1);
        chk("mr_state", 64'(debug_state), 64'(IDLE));
        chk("mr_adr", 64'(bus.adr), 64'd0);
        reset = 1'b0;
        bus.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mr_no_resp_%0d", i), 64'(resp_valid), 64'd0);
            chk($sformatf("mr_idle_cyc_%0d", i), 64'(bus.cyc), 64'd0);
        end
        bus.ack = 1'b0;

`ifdef WB_TIMEOUT_EN
        // Slave never acks: abort after 16 stb cycles
        offer(1'b0, 32'h0000_0060, 32'h0, 4'hF);
        step();
        req_valid = 1'b0;
        bus.datrd = 32'hFFFF_0000;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("to_stb_%0d", i), 64'(bus.stb), 64'd1);
            step();
        end
        chk("to_stb_drop", 64'(bus.stb), 64'd0);
        chk("to_cyc_drop", 64'(bus.cyc), 64'd0);
        chk("to_resp_valid", 64'(resp_valid), 64'd1);
        chk("to_resp_err", 64'(resp_err), 64'd1);
        chk("to_resp_data", 64'(resp_data), 64'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("to_done", 64'(resp_valid), 64'd0);

        // ack in the 16th stb cycle completes normally
        offer(1'b0, 32'h0000_0064, 32'h0, 4'hF);
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("ta_stb_%0d", i), 64'(bus.stb), 64'd1);
            if (i == 16) begin
                bus.ack = 1'b1; bus.datrd = 32'h1111_2222;
            end
            step();
        end
        bus.ack = 1'b0;
        chk("ta_resp_valid", 64'(resp_valid), 64'd1);
        chk("ta_resp_err", 64'(resp_err), 64'd0);
        chk("ta_resp_data", 64'(resp_data), 64'h1111_2222);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
`else
        // Without the watchdog the bridge waits for ack indefinitely
        offer(1'b0, 32'h0000_0050, 32'h0, 4'hF);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("nt_stb_%0d", i), 64'(bus.stb), 64'd1);
            chk($sformatf("nt_no_resp_%0d", i), 64'(resp_valid), 64'd0);
            step();
        end
        bus.ack = 1'b1; bus.datrd = 32'h1212_1212;
        step();
        bus.ack = 1'b0;
        chk("nt_resp_valid", 64'(resp_valid), 64'd1);
        chk("nt_resp_err", 64'(resp_err), 64'd0);
        chk("nt_resp_data", 64'(resp_data), 64'h1212_1212);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
`endif
        chk("end_idle", 64'(debug_state), 64'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
